// File: rtl/jpeg_quantizer.sv
// JPEG coefficient quantizer: multiply by a per-position reciprocal, round half away
// from zero, saturate. Two-stage pipeline that stalls as a whole on output back-pressure.
module jpeg_quantizer #(
    parameter int IN_W    = 11,
    parameter int OUT_W   = 11,
    parameter int RECIP_W = 12
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_coeff,
    input  logic [1:0]         chan_sel,
    input  logic               tbl_we,
    input  logic               tbl_sel,
    input  logic [5:0]         tbl_addr,
    input  logic [RECIP_W:0]   tbl_data,
    output logic               tbl_err,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_coeff,
    output logic               out_last,
    output logic [1:0]         out_chan
);
    localparam int P_W = IN_W + RECIP_W + 2;
    localparam logic [RECIP_W:0] RECIP_ONE = {1'b1, {RECIP_W{1'b0}}};
    localparam logic [P_W:0] HALF    = {{(P_W+1-RECIP_W){1'b0}}, 1'b1, {(RECIP_W-1){1'b0}}};
    localparam logic [P_W:0] POS_MAX = {{(P_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic [P_W:0] NEG_MAG = {{(P_W+1-OUT_W){1'b0}}, 1'b1, {(OUT_W-1){1'b0}}};

    logic [RECIP_W:0]        r_tbl [0:1][0:63];
    logic [5:0]              r_idx;
    logic [1:0]              r_chan;
    logic                    r_s1_vld;
    logic signed [P_W-1:0]   r_s1_prod;
    logic                    r_s1_last;
    logic [1:0]              r_s1_chan;
    logic                    r_s2_vld;
    logic [OUT_W-1:0]        r_s2_coeff;
    logic                    r_s2_last;
    logic [1:0]              r_s2_chan;
    logic                    r_tbl_err;

    logic                    w_adv;
    logic                    w_in_fire;
    logic                    w_tbl_ok;
    logic                    w_neg;
    logic [1:0]              w_chan;
    logic [RECIP_W:0]        w_recip;
    logic signed [P_W-1:0]   w_a;
    logic signed [P_W-1:0]   w_b;
    logic signed [P_W-1:0]   w_prod;
    logic [P_W-1:0]          w_mag;
    logic [P_W:0]            w_rnd;
    logic [P_W:0]            w_sh;
    logic [OUT_W-1:0]        w_q;

    assign w_adv     = !(r_s2_vld && !out_ready);
    assign w_in_fire = in_valid && w_adv;
    assign in_ready  = w_adv;

    // Component is taken live on coefficient 0 and held from the latched copy afterwards
    assign w_chan  = (r_idx == 6'd0) ? chan_sel : r_chan;
    assign w_recip = r_tbl[w_chan != 2'd0][r_idx];

    assign w_a    = P_W'($signed(in_coeff));
    assign w_b    = P_W'($signed({1'b0, w_recip}));
    assign w_prod = w_a * w_b;

    assign w_tbl_ok = tbl_we && (r_idx == 6'd0) && !r_s1_vld && !r_s2_vld;

    assign w_neg = r_s1_prod[P_W-1];
    assign w_mag = w_neg ? -r_s1_prod : r_s1_prod;
    assign w_rnd = {1'b0, w_mag} + HALF;
    assign w_sh  = w_rnd >> RECIP_W;

    always_comb begin
        w_q = w_sh[OUT_W-1:0];
        if (w_neg) begin
            if (w_sh > NEG_MAG) w_q = {1'b1, {(OUT_W-1){1'b0}}};
            else                w_q = -w_sh[OUT_W-1:0];
        end else if (w_sh > POS_MAX) begin
            w_q = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < 2; s++)
                for (int a = 0; a < 64; a++)
                    r_tbl[s][a] <= RECIP_ONE;
        end else if (w_tbl_ok) begin
            r_tbl[tbl_sel][tbl_addr] <= tbl_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx      <= '0;
            r_chan     <= '0;
            r_s1_vld   <= 1'b0;
            r_s1_prod  <= '0;
            r_s1_last  <= 1'b0;
            r_s1_chan  <= '0;
            r_s2_vld   <= 1'b0;
            r_s2_coeff <= '0;
            r_s2_last  <= 1'b0;
            r_s2_chan  <= '0;
            r_tbl_err  <= 1'b0;
        end else begin
            r_tbl_err <= tbl_we && !w_tbl_ok;
            if (w_in_fire) begin
                r_idx <= r_idx + 6'd1;
                if (r_idx == 6'd0) r_chan <= chan_sel;
            end
            if (w_adv) begin
                r_s1_vld <= w_in_fire;
                if (w_in_fire) begin
                    r_s1_prod <= w_prod;
                    r_s1_last <= (r_idx == 6'd63);
                    r_s1_chan <= w_chan;
                end
                r_s2_vld <= r_s1_vld;
                if (r_s1_vld) begin
                    r_s2_coeff <= w_q;
                    r_s2_last  <= r_s1_last;
                    r_s2_chan  <= r_s1_chan;
                end
            end
        end
    end

    assign out_valid = r_s2_vld;
    assign out_coeff = r_s2_coeff;
    assign out_last  = r_s2_last;
    assign out_chan  = r_s2_chan;
    assign tbl_err   = r_tbl_err;

endmodule

// File: tb/tb_jpeg_quantizer.sv
// Bench for jpeg_quantizer: default instance plus an OUT_W=8 instance on shared stimulus,
// scored against an arithmetic quantization model and a few directed vector tables.
module tb_jpeg_quantizer;
    localparam int RW = 12;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, in_ready8;
    logic [10:0] in_coeff;
    logic [1:0] chan_sel;
    logic tbl_we, tbl_sel;
    logic [5:0] tbl_addr;
    logic [RW:0] tbl_data;
    logic tbl_err, tbl_err8;
    logic out_valid, out_valid8, out_ready;
    logic signed [10:0] out_coeff;
    logic signed [7:0] out_coeff8;
    logic out_last, out_last8;
    logic [1:0] out_chan, out_chan8;

    always #5 clk = ~clk;

    jpeg_quantizer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_coeff(in_coeff),
        .chan_sel(chan_sel), .tbl_we(tbl_we), .tbl_sel(tbl_sel), .tbl_addr(tbl_addr),
        .tbl_data(tbl_data), .tbl_err(tbl_err), .out_valid(out_valid), .out_ready(out_ready),
        .out_coeff(out_coeff), .out_last(out_last), .out_chan(out_chan)
    );

    jpeg_quantizer #(.IN_W(11), .OUT_W(8), .RECIP_W(RW)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8), .in_coeff(in_coeff),
        .chan_sel(chan_sel), .tbl_we(tbl_we), .tbl_sel(tbl_sel), .tbl_addr(tbl_addr),
        .tbl_data(tbl_data), .tbl_err(tbl_err8), .out_valid(out_valid8), .out_ready(out_ready),
        .out_coeff(out_coeff8), .out_last(out_last8), .out_chan(out_chan8)
    );

    typedef struct { int c11; int c8; int last; int chan; int cyc; } exp_t;
    typedef struct { int din; int e11; int e8; } vec_t;

    int errs = 0;
    int checks = 0;
    int mtbl [2][64];
    int midx = 0;
    int mchan = 0;
    exp_t sbq[$];
    int cap11[$], cap8[$], capch[$];
    bit exp_err = 1'b0;
    int cyc = 0;
    int last_nrdy = -100;
    bit hold_v = 1'b0;
    int hold_c = 0;
    int nrdy_cnt = 0;
    int errpulse = 0;
    int rdy_mode = 0;

    task automatic check(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errs++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    function automatic int quant(int c, int r, int ow);
        longint p, m, q, lo, hi;
        p = longint'(c) * longint'(r);
        m = (p < 0) ? -p : p;
        q = (m + (longint'(1) << (RW-1))) / (longint'(1) << RW);
        if (p < 0) q = -q;
        hi = (longint'(1) << (ow-1)) - 1;
        lo = -(longint'(1) << (ow-1));
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        return int'(q);
    endfunction

    // Reference model and scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        bit ok;
        int ch;
        int r;
        exp_t e;
        cyc++;
        if (rst) begin
            check("rst_flags", int'({out_valid, out_last, out_chan, tbl_err, in_ready, out_valid8}), 2);
            check("rst_coeff", int'(out_coeff), 0);
            midx = 0; mchan = 0; exp_err = 0; hold_v = 0;
            sbq.delete();
            for (int s = 0; s < 2; s++)
                for (int a = 0; a < 64; a++)
                    mtbl[s][a] = 1 << RW;
        end else begin
            check("tbl_err", int'({tbl_err, tbl_err8}), exp_err ? 3 : 0);
            check("in_ready", int'({in_ready, in_ready8}), (out_valid && !out_ready) ? 0 : 3);
            if (tbl_err) errpulse++;
            if (!in_ready) nrdy_cnt++;
            if (!out_ready) last_nrdy = cyc;
            if (hold_v) begin
                check("stall_valid", int'(out_valid), 1);
                check("stall_hold", int'(out_coeff), hold_c);
            end
            hold_v = out_valid && !out_ready;
            hold_c = int'(out_coeff);
            ok = tbl_we && (midx == 0) && (sbq.size() == 0);
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    check("unexpected_out", int'(out_valid), 0);
                end else begin
                    e = sbq.pop_front();
                    check("coeff", int'(out_coeff), e.c11);
                    check("coeff8", int'(out_coeff8), e.c8);
                    check("valid8", int'(out_valid8), 1);
                    check("last", int'({out_last, out_last8}), e.last ? 3 : 0);
                    check("chan", int'(out_chan), e.chan);
                    check("chan8", int'(out_chan8), e.chan);
                    if (e.cyc > last_nrdy) check("latency", cyc - e.cyc, 2);
                    cap11.push_back(int'(out_coeff));
                    cap8.push_back(int'(out_coeff8));
                    capch.push_back(int'(out_chan));
                end
            end
            if (in_valid && in_ready) begin
                ch = (midx == 0) ? int'(chan_sel) : mchan;
                if (midx == 0) mchan = ch;
                r = mtbl[(ch != 0) ? 1 : 0][midx];
                e.c11 = quant(int'($signed(in_coeff)), r, 11);
                e.c8 = quant(int'($signed(in_coeff)), r, 8);
                e.last = (midx == 63) ? 1 : 0;
                e.chan = ch;
                e.cyc = cyc;
                sbq.push_back(e);
                midx = (midx + 1) % 64;
            end
            if (ok) mtbl[tbl_sel][tbl_addr] = int'(tbl_data);
            exp_err = tbl_we && !ok;
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic send(input int c, input int ch);
        bit acc;
        int n;
        n = 0;
        in_valid = 1'b1;
        in_coeff = 11'(c);
        chan_sel = 2'(ch);
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 200);
        check("send_accept", int'(acc), 1);
    endtask

    task automatic send_blk(input int vals[64], input int ch, input bit gaps);
        for (int i = 0; i < 64; i++) begin
            send(vals[i], ch);
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk); #1;
        check("drain", sbq.size(), 0);
    endtask

    task automatic tbl_write(input int sel, input int addr, input int data);
        tbl_we = 1'b1;
        tbl_sel = sel[0];
        tbl_addr = 6'(addr);
        tbl_data = 13'(data);
        @(posedge clk); #1;
        tbl_we = 1'b0;
    endtask

    task automatic clear_caps();
        cap11.delete(); cap8.delete(); capch.delete();
    endtask

    task automatic rand_vals(output int v[64]);
        for (int i = 0; i < 64; i++) v[i] = int'($urandom_range(0, 2047)) - 1024;
    endtask

    initial begin
        int vals[64];
        vec_t vt[9];
        vt[0] = '{200, 200, 127};    vt[1] = '{-300, -300, -128};
        vt[2] = '{1023, 1023, 127};  vt[3] = '{-1024, -1024, -128};
        vt[4] = '{0, 0, 0};          vt[5] = '{127, 127, 127};
        vt[6] = '{-128, -128, -128}; vt[7] = '{128, 128, 127};
        vt[8] = '{-129, -129, -128};

        rst = 1'b1; in_valid = 1'b0; in_coeff = '0; chan_sel = '0;
        tbl_we = 1'b0; tbl_sel = 1'b0; tbl_addr = '0; tbl_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Identity tables: 200..263 pass through unchanged
        clear_caps();
        for (int i = 0; i < 64; i++) vals[i] = 200 + i;
        send_blk(vals, 0, 0);
        drain();
        for (int i = 0; i < 64; i++) check("ident_blk", cap11[i], 200 + i);

        // Saturation vectors for both output widths
        clear_caps();
        rand_vals(vals);
        for (int i = 0; i < 9; i++) vals[i] = vt[i].din;
        send_blk(vals, 2, 1);
        drain();
        for (int i = 0; i < 9; i++) begin
            check("vec11", cap11[i], vt[i].e11);
            check("vec8", cap8[i], vt[i].e8);
        end

        // Chroma reciprocals Q=17, Q=17, Q=99
        tbl_write(1, 0, 241);
        tbl_write(1, 1, 241);
        tbl_write(1, 2, 41);
        clear_caps();
        rand_vals(vals);
        vals[0] = 200; vals[1] = -1; vals[2] = 50;
        send_blk(vals, 1, 0);
        drain();
        check("cb_q0", cap11[0], 12);
        check("cb_q1", cap11[1], 0);
        check("cb_q2", cap11[2], 1);
        check("cb_chan", capch[0], 1);

        // Table write in the same cycle as coefficient 0 uses the old entry
        clear_caps();
        rand_vals(vals);
        vals[0] = 100;
        tbl_we = 1'b1; tbl_sel = 1'b0; tbl_addr = 6'd0; tbl_data = 13'd2048;
        send(100, 0);
        tbl_we = 1'b0;
        for (int i = 1; i < 64; i++) send(vals[i], 0);
        in_valid = 1'b0;
        drain();
        check("wr_same_cycle_old", cap11[0], 100);
        clear_caps();
        send_blk(vals, 0, 0);
        drain();
        check("wr_new_entry", cap11[0], 50);

        // Five-cycle output stall mid-block
        clear_caps();
        rand_vals(vals);
        nrdy_cnt = 0;
        fork
            send_blk(vals, 2, 0);
            begin
                repeat (20) @(posedge clk);
                rdy_mode = 2;
                repeat (5) @(posedge clk);
                rdy_mode = 0;
            end
        join
        drain();
        check("stall_count", cap11.size(), 64);
        check("stall_inrdy_low", nrdy_cnt, 5);

        // Rejected write at index 10, then reset at index 30
        clear_caps();
        errpulse = 0;
        rand_vals(vals);
        for (int i = 0; i < 10; i++) send(vals[i], 0);
        tbl_we = 1'b1; tbl_sel = 1'b0; tbl_addr = 6'd5; tbl_data = 13'd1;
        send(vals[10], 0);
        tbl_we = 1'b0;
        for (int i = 11; i < 30; i++) send(vals[i], 0);
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("tbl_err_pulses", errpulse, 1);
        clear_caps();
        rand_vals(vals);
        vals[0] = 77;
        send_blk(vals, 1, 0);
        drain();
        check("post_rst_c0", cap11[0], 77);
        check("post_rst_c1", cap11[1], vals[1]);
        check("post_rst_c2", cap11[2], vals[2]);
        check("post_rst_len", cap11.size(), 64);

        // Randomized blocks with back-pressure and table traffic
        rdy_mode = 1;
        for (int b = 0; b < 6; b++) begin
            rand_vals(vals);
            send_blk(vals, int'($urandom_range(0, 3)), 1);
            if ($urandom_range(0, 1) == 1) drain();
            for (int k = 0; k < 3; k++)
                tbl_write(int'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
                          int'($urandom_range(1, 8191)));
        end
        rdy_mode = 0;
        drain();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errs, checks);
        $fatal(1);
    end

endmodule
